// File: rtl/membrane_integrator_pkg.sv
// rtl/membrane_integrator_pkg.sv - shared widths, FSM states and fixed-point helpers for the integrator
package membrane_integrator_pkg;

    localparam int INTEGER_WIDTH   = 16;
    localparam int DATA_WIDTH_FRAC = 32;
    localparam int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC;
    localparam int REFRACT_WIDTH   = 8;
    localparam int SHIFT_WIDTH     = 5;

    localparam logic signed [DATA_WIDTH-1:0] FX_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] FX_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        LEAK  = 2'd2,
        FIRE  = 2'd3
    } mi_state_e;

    // Integer-valued potential placed in the integer field with a zero fraction.
    function automatic logic signed [DATA_WIDTH-1:0] fx_extend(
        input logic signed [INTEGER_WIDTH-1:0] x
    );
        return {x, {DATA_WIDTH_FRAC{1'b0}}};
    endfunction

    // Signed add that pins to the representable extremes instead of wrapping.
    function automatic logic signed [DATA_WIDTH-1:0] fx_sat_add(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        logic signed [DATA_WIDTH:0] s;
        s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
        if (s[DATA_WIDTH] != s[DATA_WIDTH-1]) begin
            return s[DATA_WIDTH] ? FX_MIN : FX_MAX;
        end
        return s[DATA_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/membrane_integrator_fixed_point_sat_adder.sv
// rtl/membrane_integrator_fixed_point_sat_adder.sv - fixed-point adder, clamping when MEMBRANE_SATURATION_EN is defined
module fixed_point_sat_adder
    import membrane_integrator_pkg::*;
(
    input  logic signed [DATA_WIDTH-1:0] a_i,
    input  logic signed [DATA_WIDTH-1:0] b_i,
    output logic signed [DATA_WIDTH-1:0] sum_o
);

    // Clamp in the saturating build, plain modular add otherwise.
    always_comb begin
`ifdef MEMBRANE_SATURATION_EN
        sum_o = fx_sat_add(a_i, b_i);
`else
        sum_o = a_i + b_i;
`endif
    end

endmodule

// File: rtl/membrane_integrator.sv
// rtl/membrane_integrator.sv - per-neuron membrane integrator with leak, threshold and refractory hold (MEMBRANE_SATURATION_EN selects clamping adds)
module membrane_integrator
    import membrane_integrator_pkg::*;
(
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            init_i,
    input  logic                            start_i,
    input  logic signed [INTEGER_WIDTH-1:0] vrest_i,
    input  logic signed [INTEGER_WIDTH-1:0] vthresh_i,
    input  logic signed [INTEGER_WIDTH-1:0] vreset_i,
    input  logic        [SHIFT_WIDTH-1:0]   leak_shift_i,
    input  logic        [REFRACT_WIDTH-1:0] refract_period_i,
    input  logic signed [DATA_WIDTH-1:0]    ipsc_in_i,
    input  logic                            ipsc_valid_i,
    input  logic                            ipsc_last_i,
    output logic                            ipsc_ready_o,
    output logic signed [DATA_WIDTH-1:0]    vmem_out_o,
    output logic                            spike_o,
    output logic                            done_o,
    output logic                            busy_o
);

    mi_state_e                       state_q, state_d;
    logic signed [DATA_WIDTH-1:0]    vmem_q, vmem_d;
    logic signed [DATA_WIDTH-1:0]    acc_q, acc_d;
    logic signed [DATA_WIDTH-1:0]    vnext_q, vnext_d;
    logic        [REFRACT_WIDTH-1:0] refract_q, refract_d;
    logic                            hold_q, hold_d;
    logic                            spike_q, spike_d;
    logic                            done_q, done_d;

    logic signed [DATA_WIDTH-1:0]    vrest_ext, vthresh_ext, vreset_ext;
    logic signed [DATA_WIDTH-1:0]    leak_diff, leak_term;
    logic signed [DATA_WIDTH-1:0]    acc_sum, vm_acc_sum, leak_sum;

    assign vrest_ext   = fx_extend(vrest_i);
    assign vthresh_ext = fx_extend(vthresh_i);
    assign vreset_ext  = fx_extend(vreset_i);

    // Leak pulls Vmem toward rest by a power-of-two fraction; >>> floors negative values.
    assign leak_diff = vrest_ext - vmem_q;
    assign leak_term = leak_diff >>> leak_shift_i;

    fixed_point_sat_adder u_acc_add (
        .a_i   (acc_q),
        .b_i   (ipsc_in_i),
        .sum_o (acc_sum)
    );

    fixed_point_sat_adder u_vm_acc_add (
        .a_i   (vmem_q),
        .b_i   (acc_q),
        .sum_o (vm_acc_sum)
    );

    fixed_point_sat_adder u_leak_add (
        .a_i   (vm_acc_sum),
        .b_i   (leak_term),
        .sum_o (leak_sum)
    );

    // State and datapath registers; reset abandons any step in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            vmem_q    <= '0;
            acc_q     <= '0;
            vnext_q   <= '0;
            refract_q <= '0;
            hold_q    <= 1'b0;
            spike_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            vmem_q    <= vmem_d;
            acc_q     <= acc_d;
            vnext_q   <= vnext_d;
            refract_q <= refract_d;
            hold_q    <= hold_d;
            spike_q   <= spike_d;
            done_q    <= done_d;
        end
    end

    // Next-state and datapath updates for IDLE -> ACCUM -> LEAK -> FIRE -> IDLE.
    always_comb begin
        state_d   = state_q;
        vmem_d    = vmem_q;
        acc_d     = acc_q;
        vnext_d   = vnext_q;
        refract_d = refract_q;
        hold_d    = hold_q;
        spike_d   = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (init_i) begin
                    vmem_d    = vrest_ext;
                    refract_d = '0;
                end else if (start_i) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (ipsc_valid_i) begin
                    acc_d = acc_sum;
                    if (ipsc_last_i) begin
                        state_d = LEAK;
                    end
                end
            end
            LEAK: begin
                // While refractory the accumulated input is dropped entirely.
                if (refract_q != '0) begin
                    vnext_d   = vreset_ext;
                    refract_d = refract_q - 1'b1;
                    hold_d    = 1'b1;
                end else begin
                    vnext_d = leak_sum;
                    hold_d  = 1'b0;
                end
                state_d = FIRE;
            end
            FIRE: begin
                if (!hold_q && (vnext_q >= vthresh_ext)) begin
                    vmem_d    = vreset_ext;
                    spike_d   = 1'b1;
                    refract_d = refract_period_i;
                end else begin
                    vmem_d = vnext_q;
                end
                done_d  = 1'b1;
                acc_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ipsc_ready_o = (state_q == ACCUM);
    assign busy_o       = (state_q != IDLE);
    assign vmem_out_o   = vmem_q;
    assign spike_o      = spike_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_membrane_integrator.sv
// tb/tb_membrane_integrator.sv - directed self-checking bench for membrane_integrator
module tb_membrane_integrator;

    logic               clk = 1'b0;
    logic               rst_ni;
    logic               init_i, start_i;
    logic signed [15:0] vrest_i, vthresh_i, vreset_i;
    logic        [4:0]  leak_shift_i;
    logic        [7:0]  refract_period_i;
    logic signed [47:0] ipsc_in_i;
    logic               ipsc_valid_i, ipsc_last_i;
    logic               ipsc_ready_o;
    logic signed [47:0] vmem_out_o;
    logic               spike_o, done_o, busy_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    membrane_integrator dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .init_i           (init_i),
        .start_i          (start_i),
        .vrest_i          (vrest_i),
        .vthresh_i        (vthresh_i),
        .vreset_i         (vreset_i),
        .leak_shift_i     (leak_shift_i),
        .refract_period_i (refract_period_i),
        .ipsc_in_i        (ipsc_in_i),
        .ipsc_valid_i     (ipsc_valid_i),
        .ipsc_last_i      (ipsc_last_i),
        .ipsc_ready_o     (ipsc_ready_o),
        .vmem_out_o       (vmem_out_o),
        .spike_o          (spike_o),
        .done_o           (done_o),
        .busy_o           (busy_o)
    );

    function automatic logic signed [47:0] fx(input int v);
        logic signed [47:0] r;
        r = v;
        return r <<< 32;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_init(input int vr, input int vt, input int vs, input int sh, input int rp);
        vrest_i          = 16'(vr);
        vthresh_i        = 16'(vt);
        vreset_i         = 16'(vs);
        leak_shift_i     = 5'(sh);
        refract_period_i = 8'(rp);
        init_i = 1'b1;
        tick();
        init_i = 1'b0;
    endtask

    // Drives one time step and records what appears in the four cycles after the Last beat.
    task automatic run_step(input logic signed [47:0] b0, input logic signed [47:0] b1,
                            input logic signed [47:0] b2, input int n,
                            output logic sp, output int done_edge, output int done_cnt,
                            output logic signed [47:0] vm);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            ipsc_in_i    = (i == 0) ? b0 : ((i == 1) ? b1 : b2);
            ipsc_valid_i = 1'b1;
            ipsc_last_i  = (i == n - 1);
            tick();
        end
        ipsc_valid_i = 1'b0;
        ipsc_last_i  = 1'b0;
        ipsc_in_i    = '0;
        sp = 1'b0; done_edge = -1; done_cnt = 0; vm = '0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (done_o) begin
                done_cnt++;
                if (done_edge < 0) begin
                    done_edge = k;
                    vm = vmem_out_o;
                end
            end
            if (spike_o) sp = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        tick(); tick();
        checks++; if (vmem_out_o !== 48'sd0) begin failures++; $display("FAIL reset_vmem got=%h exp=0", vmem_out_o); end
        checks++; if (ipsc_ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ipsc_ready_o); end
        checks++; if (spike_o !== 1'b0) begin failures++; $display("FAIL reset_spike got=%b exp=0", spike_o); end
        checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic sp; int de, dc; logic signed [47:0] vm;
        do_init(-65, -52, -70, 4, 2);
        checks++; if (vmem_out_o !== fx(-65)) begin failures++; $display("FAIL init_vmem got=%h exp=%h", vmem_out_o, fx(-65)); end
        run_step(fx(5), '0, '0, 1, sp, de, dc, vm);
        checks++; if (vm !== fx(-60)) begin failures++; $display("FAIL basic_vmem got=%h exp=%h", vm, fx(-60)); end
        checks++; if (sp !== 1'b0) begin failures++; $display("FAIL basic_spike got=%b exp=0", sp); end
        checks++; if (de !== 2) begin failures++; $display("FAIL basic_done_latency got=%0d exp=2", de); end
        checks++; if (dc !== 1) begin failures++; $display("FAIL basic_done_width got=%0d exp=1", dc); end
    endtask

    task automatic test_spike();
        logic sp; int de, dc; logic signed [47:0] vm;
        run_step(fx(10), '0, '0, 1, sp, de, dc, vm);
        checks++; if (sp !== 1'b1) begin failures++; $display("FAIL spike_fire got=%b exp=1", sp); end
        checks++; if (vm !== fx(-70)) begin failures++; $display("FAIL spike_vreset got=%h exp=%h", vm, fx(-70)); end
    endtask

    task automatic test_refractory();
        logic sp; int de, dc; logic signed [47:0] vm;
        for (int s = 0; s < 2; s++) begin
            run_step(fx(20), '0, '0, 1, sp, de, dc, vm);
            checks++; if (sp !== 1'b0) begin failures++; $display("FAIL refr_spike_%0d got=%b exp=0", s, sp); end
            checks++; if (vm !== fx(-70)) begin failures++; $display("FAIL refr_vmem_%0d got=%h exp=%h", s, vm, fx(-70)); end
        end
        run_step(fx(20), '0, '0, 1, sp, de, dc, vm);
        checks++; if (sp !== 1'b1) begin failures++; $display("FAIL refr_release_spike got=%b exp=1", sp); end
        checks++; if (vm !== fx(-70)) begin failures++; $display("FAIL refr_release_vmem got=%h exp=%h", vm, fx(-70)); end
    endtask

    task automatic test_leak_fraction();
        logic sp; int de, dc; logic signed [47:0] vm;
        do_init(-65, 100, -70, 4, 2);
        run_step(fx(-3), '0, '0, 1, sp, de, dc, vm);
        checks++; if (vm !== fx(-68)) begin failures++; $display("FAIL leak_neg_vmem got=%h exp=%h", vm, fx(-68)); end
        run_step('0, '0, '0, 1, sp, de, dc, vm);
        checks++; if (vm !== fx(-68) + 48'sh0000_3000_0000) begin failures++; $display("FAIL leak_frac_vmem got=%h exp=%h", vm, fx(-68) + 48'sh0000_3000_0000); end
    endtask

    task automatic test_saturation();
        logic sp; int de, dc; logic signed [47:0] vm, big, exp_vm; logic exp_sp;
        big = 48'sh7FFF_0000_0000;
`ifdef MEMBRANE_SATURATION_EN
        exp_vm = fx(-70);
        exp_sp = 1'b1;
`else
        exp_vm = 48'sh7FFD_0000_0000;
        exp_sp = 1'b0;
`endif
        do_init(0, 32767, -70, 4, 0);
        run_step(big, big, big, 3, sp, de, dc, vm);
        checks++; if (vm !== exp_vm) begin failures++; $display("FAIL overflow_vmem got=%h exp=%h", vm, exp_vm); end
        checks++; if (sp !== exp_sp) begin failures++; $display("FAIL overflow_spike got=%b exp=%b", sp, exp_sp); end
    endtask

    task automatic test_back_to_back();
        int dc;
        do_init(-65, 100, -70, 4, 0);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            ipsc_in_i    = fx(i);
            ipsc_valid_i = 1'b1;
            ipsc_last_i  = (i == 3);
            tick();
        end
        ipsc_in_i   = fx(50);
        ipsc_last_i = 1'b1;
        start_i     = 1'b1;
        checks++; if (ipsc_ready_o !== 1'b0) begin failures++; $display("FAIL bp_ready_leak got=%b exp=0", ipsc_ready_o); end
        checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL bp_busy_leak got=%b exp=1", busy_o); end
        tick();
        checks++; if (ipsc_ready_o !== 1'b0) begin failures++; $display("FAIL bp_ready_fire got=%b exp=0", ipsc_ready_o); end
        dc = 0;
        tick();
        if (done_o) dc++;
        start_i      = 1'b0;
        ipsc_valid_i = 1'b0;
        ipsc_last_i  = 1'b0;
        checks++; if (vmem_out_o !== fx(-59)) begin failures++; $display("FAIL bp_vmem got=%h exp=%h", vmem_out_o, fx(-59)); end
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done_o) dc++;
        end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL bp_start_ignored got=%b exp=0", busy_o); end
        checks++; if (dc !== 1) begin failures++; $display("FAIL bp_done_count got=%0d exp=1", dc); end
    endtask

    task automatic test_reset_mid();
        logic sp; int de, dc; logic signed [47:0] vm;
        start_i = 1'b1;
        tick();
        start_i      = 1'b0;
        ipsc_in_i    = fx(7);
        ipsc_valid_i = 1'b1;
        ipsc_last_i  = 1'b0;
        tick();
        ipsc_valid_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        checks++; if (vmem_out_o !== 48'sd0) begin failures++; $display("FAIL midrst_vmem got=%h exp=0", vmem_out_o); end
        checks++; if (ipsc_ready_o !== 1'b0) begin failures++; $display("FAIL midrst_ready got=%b exp=0", ipsc_ready_o); end
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy_o); end
        checks++; if (done_o !== 1'b0) begin failures++; $display("FAIL midrst_done got=%b exp=0", done_o); end
        tick();
        rst_ni = 1'b1;
        tick();
        vrest_i = -16'sd65;
        init_i  = 1'b1;
        start_i = 1'b1;
        tick();
        init_i  = 1'b0;
        start_i = 1'b0;
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL init_wins_busy got=%b exp=0", busy_o); end
        checks++; if (vmem_out_o !== fx(-65)) begin failures++; $display("FAIL init_wins_vmem got=%h exp=%h", vmem_out_o, fx(-65)); end
        run_step(fx(5), '0, '0, 1, sp, de, dc, vm);
        checks++; if (vm !== fx(-60)) begin failures++; $display("FAIL post_rst_vmem got=%h exp=%h", vm, fx(-60)); end
        checks++; if (de !== 2) begin failures++; $display("FAIL post_rst_done got=%0d exp=2", de); end
    endtask

    initial begin
        rst_ni = 1'b0; init_i = 1'b0; start_i = 1'b0;
        vrest_i = '0; vthresh_i = '0; vreset_i = '0;
        leak_shift_i = '0; refract_period_i = '0;
        ipsc_in_i = '0; ipsc_valid_i = 1'b0; ipsc_last_i = 1'b0;
        test_reset();
        test_basic();
        test_spike();
        test_refractory();
        test_leak_fraction();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
